// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential signed ALU with valid/ready handshakes
// Single-cycle ops register on accept; MUL runs one shift-add step per cycle.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_HOLD
  } state_t;

  state_t state, state_nxt;

  logic                   accept;
  logic                   last_step;
  logic [CW-1:0]          cnt;
  logic [2*WIDTH-1:0]     acc;
  logic [2*WIDTH-1:0]     mcand;
  logic [2*WIDTH-1:0]     addend;
  logic [2*WIDTH-1:0]     acc_nxt;
  logic [WIDTH-1:0]       mplier;
  logic [WIDTH-1:0]       sum;
  logic [WIDTH-1:0]       diff;
  logic [WIDTH-1:0]       alu_res;
  logic                   alu_v;

  assign accept    = in_valid & in_ready;
  assign last_step = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = (op == OP_MUL) ? S_MUL : S_HOLD;
        end
      end
      S_MUL: begin
        if (last_step) begin
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            state_nxt = (op == OP_MUL) ? S_MUL : S_HOLD;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    sum     = in0 + in1;
    diff    = in0 - in1;
    alu_res = '0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum;
        alu_v   = (in0[WIDTH-1] == in1[WIDTH-1]) && (sum[WIDTH-1] != in0[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_v   = (in0[WIDTH-1] != in1[WIDTH-1]) && (diff[WIDTH-1] != in0[WIDTH-1]);
      end
      OP_AND:  alu_res = in0 & in1;
      OP_OR:   alu_res = in0 | in1;
      OP_XOR:  alu_res = in0 ^ in1;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(in0) < $signed(in1))};
      default: alu_res = '0;
    endcase
  end

  // The multiplier's sign bit carries negative weight, so the final step subtracts.
  always_comb begin
    addend = '0;
    if (mplier[0]) begin
      addend = last_step ? ('0 - mcand) : mcand;
    end
    acc_nxt = acc + addend;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out    <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_v <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (accept) begin
      if (op == OP_MUL) begin
        mcand  <= {{WIDTH{in0[WIDTH-1]}}, in0};
        mplier <= in1;
        acc    <= '0;
        cnt    <= '0;
      end else begin
        out    <= alu_res;
        flag_z <= (alu_res == '0);
        flag_n <= alu_res[WIDTH-1];
        flag_v <= alu_v;
      end
    end else if (state == S_MUL) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (last_step) begin
        out    <= acc_nxt[WIDTH-1:0];
        flag_z <= (acc_nxt[WIDTH-1:0] == '0);
        flag_n <= acc_nxt[WIDTH-1];
        // Overflow unless the upper half is a pure sign extension of the result.
        flag_v <= (acc_nxt[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){acc_nxt[WIDTH-1]}});
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed self-checking bench for seq_alu
// Drives inputs at posedge+1 and samples outputs at the same offset.
module tb_seq_alu;

  localparam int WIDTH = 8;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] ANDO = 3'b010;
  localparam logic [2:0] ORO = 3'b011;
  localparam logic [2:0] XORO = 3'b100;
  localparam logic [2:0] SLT = 3'b101;
  localparam logic [2:0] MUL = 3'b110;
  localparam logic [2:0] ZERO = 3'b111;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in0 = '0;
  logic [WIDTH-1:0] in1 = '0;
  logic [2:0]       op = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out;
  logic             flag_z;
  logic             flag_n;
  logic             flag_v;

  int n_checks = 0;
  int n_fail = 0;

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in0(in0),
    .in1(in1),
    .op(op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out(out),
    .flag_z(flag_z),
    .flag_n(flag_n),
    .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [7:0] e_out,
                           input logic e_z, input logic e_n, input logic e_v);
    check({tag, "_out"}, 32'(out), 32'(e_out));
    check({tag, "_z"}, 32'(flag_z), 32'(e_z));
    check({tag, "_n"}, 32'(flag_n), 32'(e_n));
    check({tag, "_v"}, 32'(flag_v), 32'(e_v));
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    in_valid = v;
    op = o;
    in0 = a;
    in1 = b;
  endtask

  // Accept a MUL, scramble inputs, expect 8 busy cycles then the result.
  task automatic run_mul(input string tag, input logic [7:0] a, input logic [7:0] b);
    drive(1'b1, MUL, a, b);
    tick();
    drive(1'b0, ADD, 8'hA5, 8'h3C);
    check({tag, "_busy_rdy"}, 32'(in_ready), 32'd0);
    for (int i = 1; i < WIDTH; i++) begin
      tick();
      check({tag, "_busy_rdy"}, 32'(in_ready), 32'd0);
      check({tag, "_busy_vld"}, 32'(out_valid), 32'd0);
    end
    tick();
    check({tag, "_vld"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_rdy", 32'(in_ready), 32'd1);
    check_res("rst", 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;

    out_ready = 1'b1;
    drive(1'b1, ADD, 8'd12, 8'hFC);
    tick();
    check("add_vld", 32'(out_valid), 32'd1);
    check_res("add", 8'h08, 1'b0, 1'b0, 1'b0);

    drive(1'b1, SUB, 8'd100, 8'h9C);
    tick();
    check_res("sub", 8'hC8, 1'b0, 1'b1, 1'b1);
    check("sub_rdy", 32'(in_ready), 32'd1);

    drive(1'b1, ZERO, 8'h33, 8'h44);
    tick();
    check_res("op7", 8'h00, 1'b1, 1'b0, 1'b0);

    drive(1'b1, ANDO, 8'h55, 8'hF0);
    tick();
    check_res("and", 8'h50, 1'b0, 1'b0, 1'b0);
    check("and_rdy", 32'(in_ready), 32'd1);
    drive(1'b1, ORO, 8'h55, 8'hF0);
    tick();
    check_res("or", 8'hF5, 1'b0, 1'b1, 1'b0);
    check("or_rdy", 32'(in_ready), 32'd1);
    drive(1'b1, XORO, 8'h55, 8'hF0);
    tick();
    check_res("xor", 8'hA5, 1'b0, 1'b1, 1'b0);
    check("xor_vld", 32'(out_valid), 32'd1);

    drive(1'b1, SLT, 8'hFD, 8'h02);
    tick();
    check_res("slt_t", 8'h01, 1'b0, 1'b0, 1'b0);
    drive(1'b1, SLT, 8'h02, 8'hFD);
    tick();
    check_res("slt_f", 8'h00, 1'b1, 1'b0, 1'b0);
    drive(1'b1, ADD, 8'h7F, 8'h01);
    tick();
    check_res("add_ovf", 8'h80, 1'b0, 1'b1, 1'b1);

    run_mul("mul_m7x6", 8'hF9, 8'h06);
    check_res("mul_m7x6", 8'hD6, 1'b0, 1'b1, 1'b0);
    run_mul("mul_16x16", 8'h10, 8'h10);
    check_res("mul_16x16", 8'h00, 1'b1, 1'b0, 1'b1);
    run_mul("mul_minx1", 8'h80, 8'hFF);
    check_res("mul_minx1", 8'h80, 1'b0, 1'b1, 1'b1);
    run_mul("mul_m1m1", 8'hFF, 8'hFF);
    check_res("mul_m1m1", 8'h01, 1'b0, 1'b0, 1'b0);

    drive(1'b0, ADD, 8'h00, 8'h00);
    tick();
    check("idle_vld", 32'(out_valid), 32'd0);
    check("idle_rdy", 32'(in_ready), 32'd1);

    out_ready = 1'b0;
    drive(1'b1, ADD, 8'd3, 8'd4);
    tick();
    check_res("bp_first", 8'h07, 1'b0, 1'b0, 1'b0);
    drive(1'b1, SUB, 8'd9, 8'd9);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_vld", 32'(out_valid), 32'd1);
      check("bp_rdy", 32'(in_ready), 32'd0);
      check_res("bp_hold", 8'h07, 1'b0, 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_rel_rdy", 32'(in_ready), 32'd1);
    drive(1'b0, ADD, 8'h00, 8'h00);
    tick();
    check("bp_done_vld", 32'(out_valid), 32'd0);
    check("bp_done_out", 32'(out), 32'h07);

    drive(1'b1, MUL, 8'd5, 8'd5);
    tick();
    drive(1'b0, ADD, 8'h00, 8'h00);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("mrst_vld", 32'(out_valid), 32'd0);
    check("mrst_rdy", 32'(in_ready), 32'd1);
    check_res("mrst", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    drive(1'b1, ADD, 8'd1, 8'd1);
    tick();
    check("post_vld", 32'(out_valid), 32'd1);
    check_res("post", 8'h02, 1'b0, 1'b0, 1'b0);
    drive(1'b0, ADD, 8'h00, 8'h00);
    repeat (WIDTH + 1) tick();
    check("stale_vld", 32'(out_valid), 32'd0);
    check("stale_out", 32'(out), 32'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 4..32).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  request present on in0/in1/op.
REQ-005 SHALL have port in_ready  output  1  block accepts request this cycle.
REQ-006 SHALL have ports in0, in1  input  WIDTH each  signed two's-complement operands.
REQ-007 SHALL have port op  input  3  operation select.
REQ-008 SHALL have port out_valid  output  1  result present on out/flags.
REQ-009 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-010 SHALL have port out  output  WIDTH  signed result.
REQ-011 SHALL have ports flag_z, flag_n, flag_v  output  1 each  zero, negative, signed overflow.

Function
REQ-012 SHALL decode op: 000 ADD, 001 SUB (in0-in1), 010 AND, 011 OR, 100 XOR, 101 SLT (out=1 if in0<in1 signed, else 0), 110 MUL (low WIDTH bits of signed product), 111 out=0.
REQ-013 SHALL accept a request on a rising edge where in_valid=1 and in_ready=1; operands and op captured at that edge, later input changes ignored.
REQ-014 SHALL implement FSM states IDLE, MUL, HOLD; reset state IDLE.
REQ-015 IDLE: in_ready=1, out_valid=0; accept of non-MUL op -> HOLD with result registered at that edge (latency 1); accept of MUL -> MUL.
REQ-016 MUL: in_ready=0, out_valid=0; iterative multiply, one step per cycle, exactly WIDTH cycles; on the WIDTH-th edge result registered, -> HOLD (latency WIDTH+1 from accept edge).
REQ-017 HOLD: out_valid=1; out and flags stable until handshake; in_ready=out_ready.
REQ-018 HOLD with out_ready=1 and in_valid=0 -> IDLE; with out_ready=1 and in_valid=1 new request accepted same edge (back-to-back, next state per REQ-015 rules); out_ready=0 -> stay HOLD.
REQ-019 SHALL never use a combinational path from in0/in1/op to out or flags; out/flags are registers.
REQ-020 flag_z=1 iff out==0; flag_n=out[WIDTH-1].
REQ-021 flag_v: ADD/SUB standard signed overflow; MUL =1 iff full 2*WIDTH-bit signed product not representable in WIDTH bits; all other ops 0.
REQ-022 ADD/SUB/MUL results wrap modulo 2^WIDTH.
REQ-023 MUL of most-negative value by -1 SHALL give out=most-negative, flag_v=1.

Reset
REQ-024 rst_n=0 SHALL immediately (no clock) force state IDLE, in_ready=1 once released, out_valid=0, out=0, flag_z=0, flag_n=0, flag_v=0, multiply counter and partial product cleared.
REQ-025 Reset during MUL or HOLD SHALL discard the in-flight result; no out_valid produced for it.
REQ-026 First accept permitted on the first rising edge after rst_n deasserts.

Verification (WIDTH=8)
REQ-027 ADD in0=12, in1=-4, out_ready=1 -> one cycle later out_valid=1, out=8, z=0 n=0 v=0.
REQ-028 SUB in0=100, in1=-100 -> out=-56 (0xC8), n=1, v=1; op=111 -> out=0, z=1.
REQ-029 AND in0=0x55, in1=0xF0 -> out=0x50; then back-to-back OR, XOR with out_ready held 1 -> 0xF5, 0xA5 on consecutive cycles, in_ready never drops.
REQ-030 MUL in0=-7, in1=6 -> in_ready=0 for 8 cycles, out_valid on 9th edge after accept, out=-42 (0xD6), n=1, v=0; MUL 16*16 -> out=0, z=1, v=1.
REQ-031 Back-pressure: out_ready=0 for 5 cycles in HOLD -> out/flags unchanged, in_ready=0, in_valid requests not accepted; out_ready=1 -> handshake completes.
REQ-032 Assert rst_n=0 mid-MUL (cycle 4) -> out_valid=0, out=0 immediately; after release, ADD 1+1 -> out=2 with no stale MUL result.
